// File: rtl/fb_rd_arbiter.sv
// Two-requester read arbiter for a shared frame-buffer BRAM port, display first.
// Define FB_ARB_STARVE_EN to add the anti-starvation override for the processing requester.
module fb_rd_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_vld,
    output logic [DATA_W-1:0] disp_data,
    input  logic              proc_req,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic              proc_gnt,
    output logic              proc_vld,
    output logic [DATA_W-1:0] proc_data,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              disp_miss
);

    // An out-of-range configuration never grants, so a mis-built instance fails safe.
    localparam bit PARAMS_OK = (RD_LAT >= 1) && (RD_LAT <= 4) &&
                               (MAX_WAIT >= 2) && (MAX_WAIT <= 255);

    logic              starve_ovr_s;
    logic [RD_LAT-1:0] tag_vld_r;
    logic [RD_LAT-1:0] tag_own_r;
    logic              rsp_vld_s;
    logic              rsp_own_s;

`ifdef FB_ARB_STARVE_EN
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_r;

    assign starve_ovr_s = (wait_cnt_r == WAIT_MAX);

    // Consecutive cycles proc has been kept waiting; a grant or an idle cycle restarts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_r <= 8'd0;
        end else if (!proc_req || proc_gnt) begin
            wait_cnt_r <= 8'd0;
        end else if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end
`else
    assign starve_ovr_s = 1'b0;
`endif

    // Grant decision: display wins unless proc has hit the starvation threshold.
    always_comb begin
        disp_gnt = 1'b0;
        proc_gnt = 1'b0;
        if (rstn && PARAMS_OK) begin
            if (proc_req && (!disp_req || starve_ovr_s)) begin
                proc_gnt = 1'b1;
            end else if (disp_req) begin
                disp_gnt = 1'b1;
            end else begin
                disp_gnt = 1'b0;
            end
        end else begin
            proc_gnt = 1'b0;
        end
    end

    // BRAM port mux; the address is forced to zero whenever no read is issued.
    always_comb begin
        bram_en   = disp_gnt | proc_gnt;
        bram_addr = {ADDR_W{1'b0}};
        case ({disp_gnt, proc_gnt})
            2'b10:   bram_addr = disp_addr;
            2'b01:   bram_addr = proc_addr;
            default: bram_addr = {ADDR_W{1'b0}};
        endcase
        disp_miss = rstn & disp_req & ~disp_gnt;
    end

    // Tag pipeline mirrors the BRAM latency; owner bit 1 marks a proc read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_vld_r <= {RD_LAT{1'b0}};
            tag_own_r <= {RD_LAT{1'b0}};
        end else begin
            tag_vld_r[0] <= bram_en;
            tag_own_r[0] <= proc_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_own_r[i] <= tag_own_r[i-1];
            end
        end
    end

    assign rsp_vld_s = tag_vld_r[RD_LAT-1];
    assign rsp_own_s = tag_own_r[RD_LAT-1];

    // Capture returning data into the owner's register; data holds between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_vld  <= 1'b0;
            proc_vld  <= 1'b0;
            disp_data <= {DATA_W{1'b0}};
            proc_data <= {DATA_W{1'b0}};
        end else begin
            disp_vld <= rsp_vld_s & ~rsp_own_s;
            proc_vld <= rsp_vld_s & rsp_own_s;
            if (rsp_vld_s && !rsp_own_s) begin
                disp_data <= bram_dout;
            end
            if (rsp_vld_s && rsp_own_s) begin
                proc_data <= bram_dout;
            end
        end
    end

endmodule

// File: tb/tb_fb_rd_arbiter.sv
// Bench for fb_rd_arbiter: two instances (RD_LAT 2 and 4) share one stimulus stream;
// expected grants come from a vector table or a small arbitration model, responses from a queue.
`timescale 1ns/1ps
module tb_fb_rd_arbiter;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 12;
    localparam int MAX_WAIT = 16;

    typedef struct {
        logic              dr;
        logic [ADDR_W-1:0] da;
        logic              pr;
        logic [ADDR_W-1:0] pa;
        logic              edg;
        logic              epg;
    } vec_t;

    typedef struct {
        logic              owner;
        logic [DATA_W-1:0] data;
        int                due;
    } resp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              disp_req = 1'b0;
    logic              proc_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [ADDR_W-1:0] proc_addr = '0;

    logic              dg2, pg2, dv2, pv2, en2, miss2;
    logic [DATA_W-1:0] dd2, pd2, dout2;
    logic [ADDR_W-1:0] ba2;
    logic              dg4, pg4, dv4, pv4, en4, miss4;
    logic [DATA_W-1:0] dd4, pd4, dout4;
    logic [ADDR_W-1:0] ba4;

    logic [DATA_W-1:0] bram2 [0:1];
    logic [DATA_W-1:0] bram4 [0:3];
    logic [DATA_W-1:0] ld2_d = '0, ld2_p = '0, ld4_d = '0, ld4_p = '0;

    resp_t q2[$];
    resp_t q4[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    wait_m = 0;
    int    pg_cnt = 0;

    always #5 clk = ~clk;

    fb_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .MAX_WAIT(MAX_WAIT)) u_dut2 (
        .clk(clk), .rstn(rstn),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(dg2), .disp_vld(dv2), .disp_data(dd2),
        .proc_req(proc_req), .proc_addr(proc_addr), .proc_gnt(pg2), .proc_vld(pv2), .proc_data(pd2),
        .bram_en(en2), .bram_addr(ba2), .bram_dout(dout2), .disp_miss(miss2)
    );

    fb_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(4), .MAX_WAIT(MAX_WAIT)) u_dut4 (
        .clk(clk), .rstn(rstn),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(dg4), .disp_vld(dv4), .disp_data(dd4),
        .proc_req(proc_req), .proc_addr(proc_addr), .proc_gnt(pg4), .proc_vld(pv4), .proc_data(pd4),
        .bram_en(en4), .bram_addr(ba4), .bram_dout(dout4), .disp_miss(miss4)
    );

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a[DATA_W-1:0] ^ 12'hA5C;
    endfunction

    // BRAM models with 2- and 4-cycle read latency
    always @(posedge clk) begin
        bram2[0] <= mem_word(ba2);
        bram2[1] <= bram2[0];
        bram4[0] <= mem_word(ba4);
        for (int i = 1; i < 4; i++) bram4[i] <= bram4[i-1];
    end
    assign dout2 = bram2[1];
    assign dout4 = bram4[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // {proc_gnt, disp_gnt} expected from the arbitration rules and the modelled wait count
    function automatic logic [1:0] predict(input logic dr, input logic pr);
        logic ovr;
`ifdef FB_ARB_STARVE_EN
        ovr = (wait_m == MAX_WAIT);
`else
        ovr = 1'b0;
`endif
        return {pr && (!dr || ovr), dr && !ovr};
    endfunction

    task automatic chk_port(input string nm, input logic has, input resp_t r,
                            input logic dv, input logic pv,
                            input logic [DATA_W-1:0] dd, input logic [DATA_W-1:0] pd,
                            inout logic [DATA_W-1:0] ld, inout logic [DATA_W-1:0] lp);
        chk({nm, ".disp_vld"}, 64'(dv), 64'(has && !r.owner));
        chk({nm, ".proc_vld"}, 64'(pv), 64'(has && r.owner));
        if (has && !r.owner) ld = r.data;
        if (has && r.owner) lp = r.data;
        chk({nm, ".disp_data"}, 64'(dd), 64'(ld));
        chk({nm, ".proc_data"}, 64'(pd), 64'(lp));
    endtask

    task automatic step(input logic dr, input logic [ADDR_W-1:0] da,
                        input logic pr, input logic [ADDR_W-1:0] pa,
                        input logic edg, input logic epg);
        logic [ADDR_W-1:0] ea;
        resp_t r;
        logic  has;
        disp_req  = dr;
        disp_addr = da;
        proc_req  = pr;
        proc_addr = pa;
        @(negedge clk);
        ea = edg ? da : (epg ? pa : '0);
        chk("disp_gnt", 64'(dg2), 64'(edg));
        chk("proc_gnt", 64'(pg2), 64'(epg));
        chk("disp_miss", 64'(miss2), 64'(dr && !edg));
        chk("bram_en", 64'(en2), 64'(edg || epg));
        chk("bram_addr", 64'(ba2), 64'(ea));
        chk("l4.gnt", 64'({dg4, pg4, en4}), 64'({edg, epg, edg || epg}));
        chk("l4.bram_addr", 64'(ba4), 64'(ea));
        if (pg2 === 1'b1) pg_cnt++;
        if (edg || epg) begin
            r.owner = epg;
            r.data  = mem_word(ea);
            r.due   = cyc + 3;
            q2.push_back(r);
            r.due   = cyc + 5;
            q4.push_back(r);
        end
        r.owner = 1'b0; r.data = '0; r.due = 0;
        has = 1'b0;
        if (q2.size() > 0) if (q2[0].due == cyc) has = 1'b1;
        if (has) r = q2.pop_front();
        chk_port("l2", has, r, dv2, pv2, dd2, pd2, ld2_d, ld2_p);
        r.owner = 1'b0; r.data = '0; r.due = 0;
        has = 1'b0;
        if (q4.size() > 0) if (q4[0].due == cyc) has = 1'b1;
        if (has) r = q4.pop_front();
        chk_port("l4", has, r, dv4, pv4, dd4, pd4, ld4_d, ld4_p);
        if (pr && !epg) wait_m = (wait_m < MAX_WAIT) ? wait_m + 1 : MAX_WAIT;
        else wait_m = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic auto_step(input logic dr, input logic [ADDR_W-1:0] da,
                             input logic pr, input logic [ADDR_W-1:0] pa);
        logic [1:0] p;
        p = predict(dr, pr);
        step(dr, da, pr, pa, p[0], p[1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) auto_step(1'b0, '0, 1'b0, '0);
    endtask

    // Requests are held high during reset so any leaking grant is visible
    task automatic reset_cycles(input int n);
        rstn = 1'b0;
        disp_req = 1'b1;
        proc_req = 1'b1;
        q2.delete();
        q4.delete();
        wait_m = 0;
        ld2_d = '0; ld2_p = '0; ld4_d = '0; ld4_p = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst.l2", {dg2, pg2, dv2, pv2, en2, miss2, dd2, pd2, ba2}, 64'd0);
            chk("rst.l4", {dg4, pg4, dv4, pv4, en4, miss4, dd4, pd4, ba4}, 64'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        rstn = 1'b1;
    endtask

    initial begin
        vec_t              vecs [9];
        logic [1:0]        p;
        logic [ADDR_W-1:0] da, pa;
        int                first_pg, base, exp_pg, exp_first;
        vecs[0] = '{1'b0, 19'd0,       1'b0, 19'd0,       1'b0, 1'b0};
        vecs[1] = '{1'b1, 19'd5,       1'b0, 19'd0,       1'b1, 1'b0};
        vecs[2] = '{1'b0, 19'd0,       1'b1, 19'd7,       1'b0, 1'b1};
        vecs[3] = '{1'b1, 19'd8,       1'b1, 19'd9,       1'b1, 1'b0};
        vecs[4] = '{1'b1, 19'd10,      1'b1, 19'd9,       1'b1, 1'b0};
        vecs[5] = '{1'b0, 19'd0,       1'b1, 19'd9,       1'b0, 1'b1};
        vecs[6] = '{1'b1, 19'd11,      1'b0, 19'd0,       1'b1, 1'b0};
        vecs[7] = '{1'b0, 19'd0,       1'b1, 19'h7FFFF,   1'b0, 1'b1};
        vecs[8] = '{1'b1, 19'h7FFFF,   1'b0, 19'd0,       1'b1, 1'b0};
`ifdef FB_ARB_STARVE_EN
        exp_pg    = 5;
        exp_first = 16;
`else
        exp_pg    = 0;
        exp_first = 20;
`endif

        reset_cycles(2);
        for (int i = 0; i < 9; i++)
            step(vecs[i].dr, vecs[i].da, vecs[i].pr, vecs[i].pa, vecs[i].edg, vecs[i].epg);
        idle(6);

        // Display streaming addresses 0..9 back to back
        for (int a = 0; a < 10; a++) auto_step(1'b1, 19'(a), 1'b0, '0);
        idle(6);

        // Both requesters held high for 100 cycles
        pg_cnt = 0;
        da = 19'd200;
        pa = 19'd1000;
        for (int i = 0; i < 100; i++) begin
            p = predict(1'b1, 1'b1);
            auto_step(1'b1, da, 1'b1, pa);
            if (p[0]) da = da + 19'd1;
            if (p[1]) pa = pa + 19'd1;
        end
        chk("starve.proc_grants", 64'(pg_cnt), 64'(exp_pg));
        idle(6);

        // Proc waits 10 cycles, drops for one, then re-asserts
        for (int i = 0; i < 10; i++) auto_step(1'b1, 19'(500 + i), 1'b1, 19'd600);
        auto_step(1'b1, 19'd510, 1'b0, '0);
        first_pg = 20;
        base = pg_cnt;
        for (int i = 0; i < 20; i++) begin
            auto_step(1'b1, 19'(520 + i), 1'b1, 19'd601);
            if (pg_cnt != base && first_pg == 20) first_pg = i;
        end
        chk("starve.restart", 64'(first_pg), 64'(exp_first));
        idle(6);

        // Reset one cycle after two reads are issued; first grant right after release
        auto_step(1'b1, 19'd300, 1'b0, '0);
        auto_step(1'b1, 19'd301, 1'b0, '0);
        reset_cycles(1);
        auto_step(1'b1, 19'd303, 1'b0, '0);
        idle(6);

        // Alternating owners every cycle
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) auto_step(1'b1, 19'(400 + i), 1'b0, '0);
            else            auto_step(1'b0, '0, 1'b1, 19'(400 + i));
        end
        idle(7);

        chk("drain.l2", 64'(q2.size()), 64'd0);
        chk("drain.l4", 64'(q4.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_rd_arbiter.md
FB_RD_ARBITER -- requirements
Module: fb_rd_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, meaning frame-buffer address width (640x480 pixels).
REQ-002 The block SHALL have parameter DATA_W, default 12, meaning pixel width (RGB444).
REQ-003 The block SHALL have parameter RD_LAT, default 2, range 1..4, meaning BRAM read latency in clk cycles from bram_en to valid bram_dout.
REQ-004 The block SHALL have parameter MAX_WAIT, default 16, range 2..255, meaning the anti-starvation threshold in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; every register is clocked on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have ports disp_req (input, 1), disp_addr (input, ADDR_W), disp_gnt (output, 1), disp_vld (output, 1), disp_data (output, DATA_W): the VGA display requester.
REQ-008 The block SHALL have ports proc_req (input, 1), proc_addr (input, ADDR_W), proc_gnt (output, 1), proc_vld (output, 1), proc_data (output, DATA_W): the image-processing/alarm requester.
REQ-009 The block SHALL have ports bram_en (output, 1), bram_addr (output, ADDR_W) and bram_dout (input, DATA_W): the shared frame-buffer read port.
REQ-010 The block SHALL have port disp_miss, output, 1 bit: one-cycle pulse when disp_req is high but not granted.

Function
REQ-011 Handshake: a requester SHALL hold req and addr stable until it sees gnt high; a transfer occurs on each cycle where req and gnt are both high.
REQ-012 disp_gnt and proc_gnt SHALL be combinational from the current req inputs and arbiter state, and SHALL never be high in the same cycle.
REQ-013 Default priority SHALL be display over processing; proc_gnt = proc_req and not disp_req, except as modified by REQ-019.
REQ-014 bram_en SHALL equal disp_gnt OR proc_gnt; bram_addr SHALL equal the granted requester's addr, and SHALL be zero when bram_en is low.
REQ-015 A tag pipeline of RD_LAT stages, each holding {valid, owner}, SHALL track every issued read; an issue in cycle T reaches the last stage in cycle T+RD_LAT.
REQ-016 In cycle T+RD_LAT the block SHALL register bram_dout into the owner's data output and pulse that owner's vld for exactly one cycle in cycle T+RD_LAT+1, giving total latency RD_LAT+1 from grant to vld.
REQ-017 disp_data and proc_data SHALL hold their last captured value between vld pulses.
REQ-018 Back-to-back grants SHALL sustain one read per cycle; responses SHALL return in issue order with no drops.
REQ-019 Starvation (only when the REQ-024 macro is defined): wait_cnt SHALL increment on each cycle with proc_req high and proc_gnt low, saturating at MAX_WAIT; when wait_cnt equals MAX_WAIT, proc SHALL win the next arbitration even if disp_req is high.
REQ-020 wait_cnt SHALL clear on a proc grant or on any cycle with proc_req low; a proc grant and a proc_req drop in the same cycle SHALL also clear it.
REQ-021 disp_miss SHALL be high in exactly those cycles where disp_req is high and disp_gnt is low.

Reset
REQ-022 While rstn is low, all outputs SHALL be 0: gnt, vld, data, bram_en, bram_addr and disp_miss.
REQ-023 Reset asserted mid-operation SHALL clear the tag pipeline and wait_cnt, so no vld is produced for reads issued before reset; the first grant SHALL be possible in the first clk cycle after rstn deasserts.

Configuration
REQ-024 With macro FB_ARB_STARVE_EN defined, the block SHALL implement REQ-019/REQ-020; without it, wait_cnt SHALL be absent, priority SHALL be strict display-first, and proc may starve indefinitely.

Verification
REQ-025 Case: disp_req only, addresses 0..9 on consecutive cycles, RD_LAT=2. Required response: 10 consecutive disp_gnt; disp_vld from cycle 3 to cycle 12 with data in address order; proc_vld never asserts.
REQ-026 Case: both requests high in the same cycle, macro undefined, disp held for 100 cycles. Required response: proc_gnt=0 for all 100 cycles; disp_miss=0.
REQ-027 Case: both requests held high, macro defined, MAX_WAIT=16. Required response: one proc_gnt every 17 cycles; disp_miss pulses in exactly those cycles; all responses in order.
REQ-028 Case: proc_req drops after 10 waiting cycles, then re-asserts, macro defined. Required response: wait_cnt restarts from 0, and the proc override fires only after 16 further waiting cycles.
REQ-029 Case: rstn pulsed low one cycle after two reads are issued. Required response: all outputs 0 during reset; no vld for those two reads; a new disp read afterwards returns after RD_LAT+1 cycles.
REQ-030 Case: alternating disp/proc grants every cycle, RD_LAT=4. Required response: vld pulses alternate owners, each exactly 5 cycles after its grant, with data matching the issued address.
